load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Data-memory stage directly downstream of the ALU: takes the ALU result as the effective address and performs one load or store per request on the data-memory bus.
- Bus uses a req/gnt/rvalid handshake.
- Returns sign- or zero-extended load data and a completion pulse to writeback, and a busy flag that decode uses to stall.
- One transaction outstanding at a time.

Parameters:
- MAX_WAIT, 16: cycles allowed in each wait state before timeout abort; 0 disables timeout.
- CNT_W, 5: width of the wait counter; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- clk  input  1  core clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- lsu_enable_ip  input  1  request strobe from decode; sampled only in IDLE
- lsu_we_ip  input  1  1 = store, 0 = load
- lsu_size_ip  input  2  lsu_size_e: LSU_BYTE=0, LSU_HALF=1, LSU_WORD=2
- lsu_sign_ext_ip  input  1  sign-extend load data when 1
- alu_result_ip  input  32  effective address from ALU
- lsu_wdata_ip  input  32  store data, right-aligned
- lsu_busy_op  output  1  high while state != IDLE
- lsu_valid_op  output  1  one-cycle completion pulse
- lsu_rdata_op  output  32  extended load data; 0 for stores and errors
- lsu_err_op  output  1  qualifies lsu_valid_op: misaligned, bus error, or timeout
- data_req_op  output  1  bus request
- data_addr_op  output  32  word-aligned address ({addr[31:2],2'b00})
- data_we_op  output  1  bus write enable
- data_be_op  output  4  byte enables
- data_wdata_op  output  32  lane-aligned store data
- data_gnt_ip  input  1  grant; address phase ends on req&gnt
- data_rvalid_ip  input  1  response valid, for loads and stores
- data_rdata_ip  input  32  response data
- data_err_ip  input  1  bus error, qualified by rvalid

Behaviour:
- Reset: state=IDLE, counter=0. All outputs 0: lsu_busy_op, lsu_valid_op, lsu_rdata_op, lsu_err_op, data_req_op, data_addr_op, data_we_op, data_be_op, data_wdata_op.
- Reset mid-transaction drops the transaction. data_req_op is low after the reset edge. A later rvalid is ignored in IDLE.
- States (lsu_state_e): IDLE, WAIT_GNT, WAIT_RVALID.
- IDLE, enable=1, misaligned request (HALF with addr[0]=1, or WORD with addr[1:0]!=0):
  - No bus activity.
  - Next cycle: lsu_valid_op=1, lsu_err_op=1, lsu_rdata_op=0.
  - State stays IDLE.
- IDLE, enable=1, aligned request:
  - Latch we, size, sign_ext and addr[1:0].
  - Drive the data_* outputs from registers.
  - Go to WAIT_GNT; data_req_op=1 from the next cycle.
- In IDLE, enable=0 leaves everything idle.
- Enable while busy is ignored; decode must hold the request until busy falls.
- Byte enables and write data:
  - BYTE: be = 4'b0001 << off, wdata = {4{wdata[7:0]}}.
  - HALF: be = 4'b0011 << off, wdata = {2{wdata[15:0]}}.
  - WORD: be = 4'b1111, wdata unchanged.
- WAIT_GNT:
  - req and all data_* outputs are held stable until gnt.
  - On req&gnt: req drops the next cycle, go to WAIT_RVALID, counter cleared.
  - rvalid in the same cycle as gnt is not allowed by the bus contract.
- WAIT_RVALID, on rvalid:
  - Go to IDLE.
  - Next cycle: lsu_valid_op=1 and lsu_err_op=data_err_ip.
  - Load, no error: byte lane off extracted and extended to 32 bits per size and sign_ext; HALF uses lane off[1].
  - Store or error: lsu_rdata_op=0.
- Completion pulse cycle: state is IDLE and busy=0, so a new request may be accepted in that cycle (back-to-back).
- Timeout (MAX_WAIT>0):
  - Counter increments each cycle in WAIT_GNT or WAIT_RVALID.
  - If it reaches MAX_WAIT-1 without the awaited event: go to IDLE, req=0, and next cycle valid=1, err=1, rdata=0.
  - A stale rvalid arriving later is ignored.
- lsu_valid_op, lsu_err_op and lsu_rdata_op are registered and high for exactly one cycle. lsu_rdata_op returns to 0 afterwards.
- Minimum latency, enable to valid: 3 cycles (gnt in the first WAIT_GNT cycle, rvalid in the first WAIT_RVALID cycle).

Decomposition:
- CORE_PKG gains lsu_size_e, lsu_state_e, and a byte-enable lookup function.
- One sub-module, lsu_rdata_align: combinational lane select and sign/zero extension, taking (rdata, off, size, sign_ext) and returning 32 bits.
- FSM, counter and request registers stay in load_store_unit.

Test Plan:
- Load word: addr=0x100, gnt in 1st cycle, rvalid with rdata=0xDEADBEEF -> data_addr_op=0x100, be=4'hF; valid 3 cycles after enable; lsu_rdata_op=0xDEADBEEF, err=0.
- Load byte signed: addr=0x103, rdata=0x80000000 -> be=4'b1000, lsu_rdata_op=0xFFFFFF80. Same request unsigned -> 0x00000080.
- Store half: addr=0x22, wdata=0x0000ABCD, gnt held low 3 cycles -> req and outputs stable 3 cycles; data_addr_op=0x20, be=4'b1100, data_wdata_op=0xABCDABCD; valid with rdata=0 after rvalid.
- Misaligned: LSU_WORD, addr=0x101 -> data_req_op never asserts; next cycle valid=1, err=1.
- Bus error, then timeout: rvalid with data_err_ip=1 -> valid=1, err=1, rdata=0. With MAX_WAIT=4 and gnt never given -> req drops after 4 wait cycles, then valid=1, err=1.
- Reset in WAIT_RVALID, then rvalid one cycle after reset deasserts -> all outputs 0, no valid pulse. Also back-to-back: new enable in the completion-pulse cycle is accepted, req rises the next cycle.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the data-memory load/store stage.
package load_store_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  typedef enum logic [1:0] {
    LSU_BYTE = 2'd0,
    LSU_HALF = 2'd1,
    LSU_WORD = 2'd2
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_GNT    = 2'd1,
    WAIT_RVALID = 2'd2
  } lsu_state_e;

  // Byte enables for an access of the given size at byte offset off.
  function automatic logic [BE_W-1:0] lsu_byte_en(lsu_size_e size, logic [1:0] off);
    case (size)
      LSU_BYTE: return 4'b0001 << off;
      LSU_HALF: return 4'b0011 << off;
      default:  return 4'b1111;
    endcase
  endfunction

  // Replicate right-aligned store data onto every lane it could occupy.
  function automatic logic [XLEN-1:0] lsu_lane_wdata(lsu_size_e size, logic [XLEN-1:0] wdata);
    case (size)
      LSU_BYTE: return {4{wdata[7:0]}};
      LSU_HALF: return {2{wdata[15:0]}};
      default:  return wdata;
    endcase
  endfunction

  // Halfwords need even addresses; words (and the unused encoding) need word alignment.
  function automatic logic lsu_misaligned(lsu_size_e size, logic [1:0] off);
    case (size)
      LSU_BYTE: return 1'b0;
      LSU_HALF: return off[0];
      default:  return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_rdata_align.sv
// Selects the addressed lane of a load response and sign/zero extends it to 32 bits.
module lsu_rdata_align
  import load_store_unit_pkg::*;
(
  input  logic [XLEN-1:0] i_rdata,
  input  logic [1:0]      i_off,
  input  lsu_size_e       i_size,
  input  logic            i_sign_ext,
  output logic [XLEN-1:0] o_rdata_c
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_off)
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
  end

  assign w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_rdata_c = i_rdata;
    case (i_size)
      LSU_BYTE: o_rdata_c = {{24{i_sign_ext & w_byte[7]}}, w_byte};
      LSU_HALF: o_rdata_c = {{16{i_sign_ext & w_half[15]}}, w_half};
      default:  o_rdata_c = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory stage: one load or store at a time over a req/gnt/rvalid bus,
// with alignment checking, per-wait-state timeout and a one-cycle completion pulse.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            lsu_enable_ip,
  input  logic            lsu_we_ip,
  input  logic [1:0]      lsu_size_ip,
  input  logic            lsu_sign_ext_ip,
  input  logic [XLEN-1:0] alu_result_ip,
  input  logic [XLEN-1:0] lsu_wdata_ip,
  output logic            lsu_busy_op,
  output logic            lsu_valid_op,
  output logic [XLEN-1:0] lsu_rdata_op,
  output logic            lsu_err_op,
  output logic            data_req_op,
  output logic [XLEN-1:0] data_addr_op,
  output logic            data_we_op,
  output logic [BE_W-1:0] data_be_op,
  output logic [XLEN-1:0] data_wdata_op,
  input  logic            data_gnt_ip,
  input  logic            data_rvalid_ip,
  input  logic [XLEN-1:0] data_rdata_ip,
  input  logic            data_err_ip
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WAIT - 1);

  lsu_state_e      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic            r_busy;
  logic            r_valid;
  logic            r_err;
  logic [XLEN-1:0] r_rdata;
  logic            r_req;
  logic [XLEN-1:0] r_addr;
  logic            r_we;
  logic [BE_W-1:0] r_be;
  logic [XLEN-1:0] r_wdata;
  lsu_size_e       r_size;
  logic            r_sign_ext;
  logic [1:0]      r_off;

  lsu_size_e       w_size;
  logic            w_misaligned;
  logic            w_timeout;
  logic [XLEN-1:0] w_load_data;

  assign w_size       = lsu_size_e'(lsu_size_ip);
  assign w_misaligned = lsu_misaligned(w_size, alu_result_ip[1:0]);
  assign w_timeout    = (MAX_WAIT != 0) && (r_cnt == LAST_CNT);

  lsu_rdata_align u_rdata_align (
    .i_rdata    (data_rdata_ip),
    .i_off      (r_off),
    .i_size     (r_size),
    .i_sign_ext (r_sign_ext),
    .o_rdata_c  (w_load_data)
  );

  // FSM, wait counter, bus request registers and completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
      r_req      <= 1'b0;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_size     <= LSU_BYTE;
      r_sign_ext <= 1'b0;
      r_off      <= 2'b00;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (lsu_enable_ip) begin
            if (w_misaligned) begin
              r_valid <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              r_state    <= WAIT_GNT;
              r_busy     <= 1'b1;
              r_req      <= 1'b1;
              r_addr     <= {alu_result_ip[31:2], 2'b00};
              r_we       <= lsu_we_ip;
              r_be       <= lsu_byte_en(w_size, alu_result_ip[1:0]);
              r_wdata    <= lsu_lane_wdata(w_size, lsu_wdata_ip);
              r_size     <= w_size;
              r_sign_ext <= lsu_sign_ext_ip;
              r_off      <= alu_result_ip[1:0];
            end
          end
        end
        WAIT_GNT: begin
          if (data_gnt_ip) begin
            r_state <= WAIT_RVALID;
            r_req   <= 1'b0;
            r_cnt   <= '0;
          end else if (w_timeout) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_req   <= 1'b0;
            r_cnt   <= '0;
            r_valid <= 1'b1;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        WAIT_RVALID: begin
          if (data_rvalid_ip) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_valid <= 1'b1;
            r_err   <= data_err_ip;
            // Stores and errored loads return zero data.
            r_rdata <= (!r_we && !data_err_ip) ? w_load_data : '0;
          end else if (w_timeout) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_valid <= 1'b1;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_req   <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign lsu_busy_op   = r_busy;
  assign lsu_valid_op  = r_valid;
  assign lsu_err_op    = r_err;
  assign lsu_rdata_op  = r_rdata;
  assign data_req_op   = r_req;
  assign data_addr_op  = r_addr;
  assign data_we_op    = r_we;
  assign data_be_op    = r_be;
  assign data_wdata_op = r_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed-vector bench for load_store_unit with a short timeout window (MAX_WAIT=4).
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        lsu_enable_ip;
  logic        lsu_we_ip;
  logic [1:0]  lsu_size_ip;
  logic        lsu_sign_ext_ip;
  logic [31:0] alu_result_ip;
  logic [31:0] lsu_wdata_ip;
  logic        lsu_busy_op;
  logic        lsu_valid_op;
  logic [31:0] lsu_rdata_op;
  logic        lsu_err_op;
  logic        data_req_op;
  logic [31:0] data_addr_op;
  logic        data_we_op;
  logic [3:0]  data_be_op;
  logic [31:0] data_wdata_op;
  logic        data_gnt_ip;
  logic        data_rvalid_ip;
  logic [31:0] data_rdata_ip;
  logic        data_err_ip;

  int n_total = 0;
  int n_bad   = 0;

  load_store_unit #(.MAX_WAIT(4), .CNT_W(3)) dut (
    .clk             (clk),
    .reset           (reset),
    .lsu_enable_ip   (lsu_enable_ip),
    .lsu_we_ip       (lsu_we_ip),
    .lsu_size_ip     (lsu_size_ip),
    .lsu_sign_ext_ip (lsu_sign_ext_ip),
    .alu_result_ip   (alu_result_ip),
    .lsu_wdata_ip    (lsu_wdata_ip),
    .lsu_busy_op     (lsu_busy_op),
    .lsu_valid_op    (lsu_valid_op),
    .lsu_rdata_op    (lsu_rdata_op),
    .lsu_err_op      (lsu_err_op),
    .data_req_op     (data_req_op),
    .data_addr_op    (data_addr_op),
    .data_we_op      (data_we_op),
    .data_be_op      (data_be_op),
    .data_wdata_op   (data_wdata_op),
    .data_gnt_ip     (data_gnt_ip),
    .data_rvalid_ip  (data_rvalid_ip),
    .data_rdata_ip   (data_rdata_ip),
    .data_err_ip     (data_err_ip)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; samples and new drives happen 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [1:0] sz, input logic sx,
                       input logic [31:0] addr, input logic [31:0] wd);
    lsu_enable_ip   = 1'b1;
    lsu_we_ip       = we;
    lsu_size_ip     = sz;
    lsu_sign_ext_ip = sx;
    alu_result_ip   = addr;
    lsu_wdata_ip    = wd;
    tick();
    lsu_enable_ip   = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".busy"},  32'(lsu_busy_op),  32'd0);
    check({tag, ".valid"}, 32'(lsu_valid_op), 32'd0);
    check({tag, ".rdata"}, lsu_rdata_op,      32'd0);
    check({tag, ".err"},   32'(lsu_err_op),   32'd0);
    check({tag, ".req"},   32'(data_req_op),  32'd0);
  endtask

  // Full transaction: issue, hold gnt low gnt_dly cycles, then gnt, then rvalid.
  task automatic txn(input string tag, input logic we, input logic [1:0] sz, input logic sx,
                     input logic [31:0] addr, input logic [31:0] wd, input int gnt_dly,
                     input logic [31:0] rd, input logic berr,
                     input logic [31:0] e_addr, input logic [3:0] e_be,
                     input logic [31:0] e_wd, input logic [31:0] e_rd);
    issue(we, sz, sx, addr, wd);
    for (int i = 0; i <= gnt_dly; i++) begin
      check({tag, ".req"},   32'(data_req_op),   32'd1);
      check({tag, ".addr"},  data_addr_op,       e_addr);
      check({tag, ".be"},    32'(data_be_op),    32'(e_be));
      check({tag, ".wdata"}, data_wdata_op,      e_wd);
      check({tag, ".we"},    32'(data_we_op),    32'(we));
      if (i == gnt_dly) data_gnt_ip = 1'b1;
      tick();
    end
    data_gnt_ip = 1'b0;
    check({tag, ".req_drop"}, 32'(data_req_op), 32'd0);
    check({tag, ".busy"},     32'(lsu_busy_op), 32'd1);
    data_rvalid_ip = 1'b1;
    data_rdata_ip  = rd;
    data_err_ip    = berr;
    tick();
    data_rvalid_ip = 1'b0;
    data_err_ip    = 1'b0;
    data_rdata_ip  = 32'hA5A5_A5A5;
    check({tag, ".valid"},    32'(lsu_valid_op), 32'd1);
    check({tag, ".err"},      32'(lsu_err_op),   32'(berr));
    check({tag, ".rdata"},    lsu_rdata_op,      e_rd);
    check({tag, ".busy_end"}, 32'(lsu_busy_op),  32'd0);
    tick();
    check({tag, ".valid_end"}, 32'(lsu_valid_op), 32'd0);
    check({tag, ".rdata_end"}, lsu_rdata_op,      32'd0);
  endtask

  initial begin
    reset           = 1'b1;
    lsu_enable_ip   = 1'b0;
    lsu_we_ip       = 1'b0;
    lsu_size_ip     = 2'd0;
    lsu_sign_ext_ip = 1'b0;
    alu_result_ip   = '0;
    lsu_wdata_ip    = '0;
    data_gnt_ip     = 1'b0;
    data_rvalid_ip  = 1'b0;
    data_rdata_ip   = '0;
    data_err_ip     = 1'b0;
    tick();
    tick();
    check_idle_outputs("reset");
    check("reset.addr",  data_addr_op,         32'd0);
    check("reset.we",    32'(data_we_op),      32'd0);
    check("reset.be",    32'(data_be_op),      32'd0);
    check("reset.wdata", data_wdata_op,        32'd0);
    reset = 1'b0;
    tick();

    //   tag     we    sz    sx    addr          wdata         dly rdata         err   e_addr        e_be     e_wdata       e_rdata
    txn("lw",   1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0,       0, 32'hDEAD_BEEF, 1'b0, 32'h0000_0100, 4'hF,    32'h0,        32'hDEAD_BEEF);
    txn("lb_s", 1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0,       0, 32'h8000_0000, 1'b0, 32'h0000_0100, 4'b1000, 32'h0,        32'hFFFF_FF80);
    txn("lb_u", 1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0,       0, 32'h8000_0000, 1'b0, 32'h0000_0100, 4'b1000, 32'h0,        32'h0000_0080);
    txn("sh",   1'b1, 2'd1, 1'b0, 32'h0000_0022, 32'h0000_ABCD, 3, 32'h1234_5678, 1'b0, 32'h0000_0020, 4'b1100, 32'hABCD_ABCD, 32'h0);
    txn("lh_s", 1'b0, 2'd1, 1'b1, 32'h0000_0042, 32'h0,       1, 32'h8001_1234, 1'b0, 32'h0000_0040, 4'b1100, 32'h0,        32'hFFFF_8001);
    txn("lh_u", 1'b0, 2'd1, 1'b0, 32'h0000_0040, 32'h0,       0, 32'h8001_F234, 1'b0, 32'h0000_0040, 4'b0011, 32'h0,        32'h0000_F234);
    txn("sb",   1'b1, 2'd0, 1'b0, 32'h0000_0001, 32'h0000_005A, 0, 32'h0,       1'b0, 32'h0000_0000, 4'b0010, 32'h5A5A_5A5A, 32'h0);
    txn("berr", 1'b0, 2'd2, 1'b0, 32'h0000_0200, 32'h0,       0, 32'hFFFF_FFFF, 1'b1, 32'h0000_0200, 4'hF,    32'h0,        32'h0);

    // Misaligned word: no bus request, immediate error pulse, stays idle.
    issue(1'b0, 2'd2, 1'b0, 32'h0000_0101, 32'h0);
    check("mis.req",   32'(data_req_op),  32'd0);
    check("mis.busy",  32'(lsu_busy_op),  32'd0);
    check("mis.valid", 32'(lsu_valid_op), 32'd1);
    check("mis.err",   32'(lsu_err_op),   32'd1);
    check("mis.rdata", lsu_rdata_op,      32'd0);
    tick();
    check_idle_outputs("mis_after");

    // Grant never arrives: four wait cycles, then abort with error.
    issue(1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'h0);
    for (int i = 0; i < 4; i++) begin
      check("to_gnt.req", 32'(data_req_op), 32'd1);
      tick();
    end
    check("to_gnt.req_drop", 32'(data_req_op),  32'd0);
    check("to_gnt.busy",     32'(lsu_busy_op),  32'd0);
    check("to_gnt.valid",    32'(lsu_valid_op), 32'd1);
    check("to_gnt.err",      32'(lsu_err_op),   32'd1);
    check("to_gnt.rdata",    lsu_rdata_op,      32'd0);
    data_rvalid_ip = 1'b1;
    data_rdata_ip  = 32'h1111_1111;
    tick();
    data_rvalid_ip = 1'b0;
    check_idle_outputs("to_gnt_stale");

    // Response never arrives: abort after four WAIT_RVALID cycles.
    issue(1'b0, 2'd2, 1'b0, 32'h0000_0304, 32'h0);
    data_gnt_ip = 1'b1;
    tick();
    data_gnt_ip = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("to_rv.busy", 32'(lsu_busy_op), 32'd1);
      tick();
    end
    check("to_rv.valid_early", 32'(lsu_valid_op), 32'd0);
    tick();
    check("to_rv.valid", 32'(lsu_valid_op), 32'd1);
    check("to_rv.err",   32'(lsu_err_op),   32'd1);
    check("to_rv.busy0", 32'(lsu_busy_op),  32'd0);
    tick();

    // Reset while waiting for the response; a late rvalid must be ignored.
    issue(1'b0, 2'd2, 1'b0, 32'h0000_0400, 32'h0);
    data_gnt_ip = 1'b1;
    tick();
    data_gnt_ip = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle_outputs("rst_mid");
    check("rst_mid.addr", data_addr_op,      32'd0);
    check("rst_mid.be",   32'(data_be_op),   32'd0);
    tick();
    data_rvalid_ip = 1'b1;
    data_rdata_ip  = 32'h2222_2222;
    tick();
    data_rvalid_ip = 1'b0;
    check_idle_outputs("rst_late_rv");
    tick();
    check_idle_outputs("rst_late_rv2");

    // Back-to-back: new request accepted in the completion-pulse cycle.
    issue(1'b0, 2'd2, 1'b0, 32'h0000_0500, 32'h0);
    data_gnt_ip = 1'b1;
    tick();
    data_gnt_ip    = 1'b0;
    data_rvalid_ip = 1'b1;
    data_rdata_ip  = 32'h0BAD_F00D;
    tick();
    data_rvalid_ip = 1'b0;
    check("b2b.valid1", 32'(lsu_valid_op), 32'd1);
    check("b2b.rdata1", lsu_rdata_op,      32'h0BAD_F00D);
    check("b2b.busy1",  32'(lsu_busy_op),  32'd0);
    issue(1'b0, 2'd2, 1'b0, 32'h0000_0504, 32'h0);
    check("b2b.req2",   32'(data_req_op),  32'd1);
    check("b2b.addr2",  data_addr_op,      32'h0000_0504);
    check("b2b.busy2",  32'(lsu_busy_op),  32'd1);
    check("b2b.valid_gone", 32'(lsu_valid_op), 32'd0);
    data_gnt_ip = 1'b1;
    tick();
    data_gnt_ip    = 1'b0;
    data_rvalid_ip = 1'b1;
    data_rdata_ip  = 32'h1122_3344;
    tick();
    data_rvalid_ip = 1'b0;
    check("b2b.valid2", 32'(lsu_valid_op), 32'd1);
    check("b2b.rdata2", lsu_rdata_op,      32'h1122_3344);
    check("b2b.err2",   32'(lsu_err_op),   32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
